// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory responder.
//   - Memory-map constants (screen base, keyboard register address).
//   - Region-decode enum and a decode helper.
//   - Screen geometry (32 words per row, 256 rows, 8192 words total).
// No ports; imported by hack_screen_scanout and referenced by hack_data_memory.
package hack_mem_pkg;

  localparam logic [15:0] SCREEN_BASE    = 16'h4000;
  localparam logic [15:0] KBD_ADDR       = 16'h6000;
  localparam int unsigned SCREEN_ROW_WORDS = 32;
  localparam int unsigned SCREEN_ROWS      = 256;
  localparam int unsigned SCREEN_NWORDS    = SCREEN_ROW_WORDS * SCREEN_ROWS;
  localparam int unsigned SCREEN_AW        = $clog2(SCREEN_NWORDS);

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_e;

  // Classify a CPU address against a memory map described by its arguments.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int unsigned ram_words,
                                            input logic [15:0] scr_base,
                                            input int unsigned scr_words,
                                            input logic [15:0] kbd_addr);
    logic [31:0] a32;
    logic [31:0] base32;
    a32    = {16'd0, addr};
    base32 = {16'd0, scr_base};
    if (a32 < ram_words) begin
      return REG_RAM;
    end else if ((a32 >= base32) && (a32 < (base32 + scr_words))) begin
      return REG_SCREEN;
    end else if (addr == kbd_addr) begin
      return REG_KBD;
    end
    return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_screen_scanout.sv
// Screen scanout engine: walks a 13-bit word pointer over the screen and presents
// one word at a time through a one-entry output register with valid/ready handshake.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   scan_en        allow new words to be loaded
//   rd_addr        screen word index to read (current pointer)
//   rd_data        screen word at rd_addr (possibly forwarded write data)
//   pix_valid/ready/word/addr  display handshake and payload
//   frame_start    high while the presented word is word 0
module hack_screen_scanout
  import hack_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_en,
  input  logic [15:0]          rd_data,
  output logic [SCREEN_AW-1:0] rd_addr,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [15:0]          pix_word,
  output logic [SCREEN_AW-1:0] pix_addr,
  output logic                 frame_start
);

  logic [SCREEN_AW-1:0] ptr_q, ptr_d;
  logic [SCREEN_AW-1:0] addr_q, addr_d;
  logic [15:0]          word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 fs_q, fs_d;
  logic                 load;

  // Register is free when empty or being drained this cycle.
  assign load = scan_en && (!valid_q || pix_ready);

  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    word_d  = word_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    if (load) begin
      word_d  = rd_data;
      addr_d  = ptr_q;
      valid_d = 1'b1;
      fs_d    = (ptr_q == '0);
      ptr_d   = ptr_q + 1'b1;  // natural wrap 8191 -> 0
    end else if (valid_q && pix_ready) begin
      valid_d = 1'b0;
      fs_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  assign rd_addr     = ptr_q;
  assign pix_valid   = valid_q;
  assign pix_word    = word_q;
  assign pix_addr    = addr_q;
  assign frame_start = fs_q;

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: RAM, memory-mapped screen, keyboard register,
// plus a screen scanout stream for the display path.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   addressM/writeM/outM  CPU address, write strobe, write data
//   inM                   CPU read data (combinational)
//   kbd_valid/kbd_code    key code strobe from the keyboard scanner
//   scan_en, pix_*        scanout enable and display handshake
//   frame_start           presented word is screen word 0
//   err_write             sticky flag: CPU wrote at or above KBD_ADDR
// Build option: define HACK_MEM_SCAN_FWD_EN to forward a same-cycle CPU write
// of the word being loaded by the scanout straight into pix_word.
module hack_data_memory #(
  parameter int unsigned RAM_WORDS    = 16384,
  parameter logic [15:0] SCREEN_BASE  = hack_mem_pkg::SCREEN_BASE,
  parameter int unsigned SCREEN_WORDS = hack_mem_pkg::SCREEN_NWORDS,
  parameter logic [15:0] KBD_ADDR     = hack_mem_pkg::KBD_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  input  logic        scan_en,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_word,
  output logic [12:0] pix_addr,
  output logic        frame_start,
  output logic        err_write
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned SCR_AW = hack_mem_pkg::SCREEN_AW;

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];

  hack_mem_pkg::region_e region;
  logic [RAM_AW-1:0]     ram_idx;
  logic [15:0]           scr_off;
  logic [SCR_AW-1:0]     scr_idx;
  logic [15:0]           kbd_q, kbd_d;
  logic                  err_q, err_d;
  logic [SCR_AW-1:0]     scan_ptr;
  logic [15:0]           scan_data;

  assign region  = hack_mem_pkg::decode_region(addressM, RAM_WORDS, SCREEN_BASE,
                                               SCREEN_WORDS, KBD_ADDR);
  assign ram_idx = addressM[RAM_AW-1:0];
  assign scr_off = addressM - SCREEN_BASE;
  assign scr_idx = scr_off[SCR_AW-1:0];

  // CPU read path, zero latency; writes land at the edge so the old value shows.
  always_comb begin
    inM = 16'h0000;
    unique case (region)
      hack_mem_pkg::REG_RAM:    inM = ram[ram_idx];
      hack_mem_pkg::REG_SCREEN: inM = screen[scr_idx];
      hack_mem_pkg::REG_KBD:    inM = kbd_q;
      hack_mem_pkg::REG_NONE:   inM = 16'h0000;
    endcase
  end

  // Storage arrays are not reset.
  always_ff @(posedge clk) begin
    if (writeM && (region == hack_mem_pkg::REG_RAM)) begin
      ram[ram_idx] <= outM;
    end
    if (writeM && (region == hack_mem_pkg::REG_SCREEN)) begin
      screen[scr_idx] <= outM;
    end
  end

  always_comb begin
    kbd_d = kbd_q;
    err_d = err_q;
    if (kbd_valid) begin
      kbd_d = kbd_code;
    end
    if (writeM && (addressM >= KBD_ADDR)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_q <= 16'h0000;
      err_q <= 1'b0;
    end else begin
      kbd_q <= kbd_d;
      err_q <= err_d;
    end
  end

  assign err_write = err_q;

`ifdef HACK_MEM_SCAN_FWD_EN
  logic fwd_hit;
  assign fwd_hit   = writeM && (region == hack_mem_pkg::REG_SCREEN) && (scr_idx == scan_ptr);
  assign scan_data = fwd_hit ? outM : screen[scan_ptr];
`else
  // Scanout sees the pre-write value; the new value shows next frame.
  assign scan_data = screen[scan_ptr];
`endif

  hack_screen_scanout u_scanout (
    .clk         (clk),
    .reset       (reset),
    .scan_en     (scan_en),
    .rd_data     (scan_data),
    .rd_addr     (scan_ptr),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_word    (pix_word),
    .pix_addr    (pix_addr),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory: directed vector table, hand-written
// scanout sequences and a randomized phase against a behavioural memory-map model.
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        scan_en;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_word;
  logic [12:0] pix_addr;
  logic        frame_start;
  logic        err_write;

  always #5 clk = ~clk;

  hack_data_memory dut (
    .clk         (clk),
    .reset       (reset),
    .addressM    (addressM),
    .writeM      (writeM),
    .outM        (outM),
    .inM         (inM),
    .kbd_valid   (kbd_valid),
    .kbd_code    (kbd_code),
    .scan_en     (scan_en),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_word    (pix_word),
    .pix_addr    (pix_addr),
    .frame_start (frame_start),
    .err_write   (err_write)
  );

  // ---------------- reference model ----------------
  logic [15:0] ram_m [16384];
  bit          ram_k [16384];
  logic [15:0] scr_m [8192];
  bit          scr_k [8192];
  logic [15:0] kbd_m;
  bit          err_m;
  bit          v_m;
  logic [15:0] w_m;
  int          a_m;
  bit          fs_m;
  int          ptr_m;

  int tests = 0;
  int fails = 0;

  function automatic void m_read(input logic [15:0] a, output logic [15:0] v, output bit k);
    int ai;
    ai = int'(a);
    k  = 1'b1;
    v  = 16'h0000;
    if (ai < 16'h4000) begin
      v = ram_m[ai];
      k = ram_k[ai];
    end else if (ai < 16'h6000) begin
      v = scr_m[ai - 16'h4000];
      k = scr_k[ai - 16'h4000];
    end else if (ai == 16'h6000) begin
      v = kbd_m;
    end
  endfunction

  // Advance model by one clock using the inputs held across the edge.
  task automatic tick();
    int ai;
    @(posedge clk);
    ai = int'(addressM);
    if (reset) begin
      kbd_m = 16'h0; err_m = 0; v_m = 0; w_m = 16'h0; a_m = 0; fs_m = 0; ptr_m = 0;
    end else begin
      if (scan_en && (!v_m || pix_ready)) begin
        w_m = scr_m[ptr_m];
`ifdef HACK_MEM_SCAN_FWD_EN
        if (writeM && ai == 16'h4000 + ptr_m) w_m = outM;
`endif
        v_m   = 1;
        a_m   = ptr_m;
        fs_m  = (ptr_m == 0);
        ptr_m = (ptr_m + 1) % 8192;
      end else if (v_m && pix_ready) begin
        v_m  = 0;
        fs_m = 0;
      end
      if (kbd_valid) kbd_m = kbd_code;
      if (writeM && ai >= 16'h6000) err_m = 1;
    end
    if (writeM) begin
      if (ai < 16'h4000) begin
        ram_m[ai] = outM; ram_k[ai] = 1;
      end else if (ai < 16'h6000) begin
        scr_m[ai - 16'h4000] = outM; scr_k[ai - 16'h4000] = 1;
      end
    end
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [15:0] v;
    bit k;
    m_read(addressM, v, k);
    if (k) check("inM", {16'd0, inM}, {16'd0, v});
    check("pix_valid", {31'd0, pix_valid}, {31'd0, v_m});
    check("pix_addr", {19'd0, pix_addr}, a_m);
    check("pix_word", {16'd0, pix_word}, {16'd0, w_m});
    check("frame_start", {31'd0, frame_start}, {31'd0, fs_m});
    check("err_write", {31'd0, err_write}, {31'd0, err_m});
  endtask

  task automatic idle();
    writeM = 0; kbd_valid = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    addressM = a; outM = d; writeM = 1;
    tick();
    writeM = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    bit          chk;
    logic [15:0] exp_in;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [15:0] exp6;
    reset = 1; addressM = 0; writeM = 0; outM = 0; kbd_valid = 0; kbd_code = 0;
    scan_en = 0; pix_ready = 0;
    tick();
    tick();
    reset = 0;

    // Reset state
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_word", {16'd0, pix_word}, 32'd0);
    check("rst_pix_addr", {19'd0, pix_addr}, 32'd0);
    check("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check("rst_err_write", {31'd0, err_write}, 32'd0);

    // ---------------- directed vector table ----------------
    vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234};
    vecs[2]  = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 16'h0010, 16'h5678, 1'b1, 16'h1234};
    vecs[4]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 16'h5678};
    vecs[5]  = '{1'b1, 16'h3FFF, 16'hCAFE, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 16'h3FFF, 16'h0000, 1'b1, 16'hCAFE};
    vecs[7]  = '{1'b1, 16'h5FFF, 16'h0F0F, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 16'h5FFF, 16'h0000, 1'b1, 16'h0F0F};
    vecs[9]  = '{1'b0, 16'h6001, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 16'h6000, 16'h0000, 1'b1, 16'h0000};
    vecs[11] = '{1'b1, 16'h6000, 16'hBEEF, 1'b1, 16'h0000};
    vecs[12] = '{1'b0, 16'h6000, 16'h0000, 1'b1, 16'h0000};
    for (int i = 0; i < 13; i++) begin
      addressM = vecs[i].addr; outM = vecs[i].data; writeM = vecs[i].wr;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_inM", i), {16'd0, inM}, {16'd0, vecs[i].exp_in});
      tick();
    end
    writeM = 0;
    check("err_set", {31'd0, err_write}, 32'd1);
    tick(); tick();
    check("err_sticky", {31'd0, err_write}, 32'd1);
    do_reset();
    check("err_cleared", {31'd0, err_write}, 32'd0);

    // ---------------- keyboard ----------------
    kbd_code = 16'h0083; kbd_valid = 1; addressM = 16'h6000;
    tick();
    kbd_valid = 0;
    check("kbd_0083", {16'd0, inM}, 32'h0083);
    kbd_code = 16'h0000; kbd_valid = 1;
    tick();
    kbd_valid = 0;
    check("kbd_clear", {16'd0, inM}, 32'h0000);

    // ---------------- fill the screen ----------------
    for (int i = 0; i < 8192; i++) cpu_write(16'h4000 + 16'(i), 16'($urandom));
    cpu_write(16'h4000, 16'hAAAA);
    cpu_write(16'h4001, 16'h5555);

    // Back-to-back scanout, full frame wrap
    do_reset();
    scan_en = 1; pix_ready = 1;
    tick();
    check("scan_w0", {16'd0, pix_word}, 32'hAAAA);
    check("scan_a0", {19'd0, pix_addr}, 32'd0);
    check("scan_fs0", {31'd0, frame_start}, 32'd1);
    check("scan_v0", {31'd0, pix_valid}, 32'd1);
    tick();
    check("scan_w1", {16'd0, pix_word}, 32'h5555);
    check("scan_a1", {19'd0, pix_addr}, 32'd1);
    check("scan_fs1", {31'd0, frame_start}, 32'd0);
    for (int i = 0; i < 8191; i++) begin
      tick();
      check_all();
    end
    check("wrap_a0", {19'd0, pix_addr}, 32'd0);
    check("wrap_fs", {31'd0, frame_start}, 32'd1);
    check("wrap_w0", {16'd0, pix_word}, 32'hAAAA);

    // Backpressure stall
    pix_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_addr", {19'd0, pix_addr}, 32'd0);
      check("stall_word", {16'd0, pix_word}, 32'hAAAA);
      check("stall_valid", {31'd0, pix_valid}, 32'd1);
    end
    pix_ready = 1;
    tick();
    check("resume_addr", {19'd0, pix_addr}, 32'd1);
    check("resume_word", {16'd0, pix_word}, 32'h5555);

    // Scan disabled: drain then hold
    scan_en = 0;
    tick();
    check("drain_valid", {31'd0, pix_valid}, 32'd0);
    check("drain_addr", {19'd0, pix_addr}, 32'd1);

    // Same-cycle collision on word 5
    cpu_write(16'h4005, 16'h1111);
    do_reset();
    scan_en = 1; pix_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    check("coll_pre_addr", {19'd0, pix_addr}, 32'd4);
    addressM = 16'h4005; outM = 16'hFFFF; writeM = 1;
    tick();
    writeM = 0;
`ifdef HACK_MEM_SCAN_FWD_EN
    exp6 = 16'hFFFF;
`else
    exp6 = 16'h1111;
`endif
    check("coll_addr", {19'd0, pix_addr}, 32'd5);
    check("coll_word", {16'd0, pix_word}, {16'd0, exp6});
    check("coll_mem", {16'd0, inM}, 32'hFFFF);

    // ---------------- randomized phase ----------------
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset     = ($urandom_range(0, 199) == 0);
      scan_en   = ($urandom_range(0, 3) != 0);
      pix_ready = ($urandom_range(0, 2) != 0);
      kbd_valid = ($urandom_range(0, 9) == 0);
      kbd_code  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3)       addressM = 16'($urandom_range(0, 16'h3FFF));
      else if (r < 6)  addressM = 16'h4000 + 16'($urandom_range(0, 8191));
      else if (r < 8)  addressM = 16'h4000 + 16'(ptr_m);
      else if (r == 8) addressM = 16'h6000;
      else             addressM = 16'($urandom_range(16'h6000, 16'hFFFF));
      outM   = 16'($urandom);
      writeM = !reset && ($urandom_range(0, 2) == 0) &&
               (addressM < 16'h6000 || $urandom_range(0, 19) == 0);
      #1;
      check_all();
      tick();
      check_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
